// File: rtl/axis_send_arbiter.sv
// ---------------------------------------------------------------------------
// axis_send_arbiter
//
// Shares the AXI-Stream send FIFO between two sources: s0 (receive-FIFO
// loopback path) and s1 (matrix result path). Arbitration is round-robin at
// packet granularity: once a source is granted it keeps the grant until its
// packet ends (tlast, or a forced end after MAX_BEATS beats). No new packet is
// started while the send FIFO reports almost_full; a packet already under way
// always runs to completion because the FIFO margin covers MAX_BEATS.
// The send FIFO is driven through a one-stage registered output slice.
//
// Ports
//   clock, reset                 system clock, asynchronous active-high reset
//   s0_* / s1_*                  source AXI-Stream slaves (tdata/tkeep/tlast/
//                                tvalid in, tready out)
//   send_fifo_almost_full        blocks the start of new packets
//   m_*                          registered AXI-Stream master to the send FIFO
//   grant                        one-hot current owner {s1,s0}, 00 = idle
//   pkt_cnt0 / pkt_cnt1          packets completed per source (wrapping)
//   overlong                     sticky: a packet reached MAX_BEATS without tlast
// ---------------------------------------------------------------------------
module axis_send_arbiter #(
    parameter int DATA_W    = 32,
    parameter int KEEP_W    = 4,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [DATA_W-1:0] s0_tdata,
    input  logic [KEEP_W-1:0] s0_tkeep,
    input  logic              s0_tlast,
    input  logic              s0_tvalid,
    output logic              s0_tready,

    input  logic [DATA_W-1:0] s1_tdata,
    input  logic [KEEP_W-1:0] s1_tkeep,
    input  logic              s1_tlast,
    input  logic              s1_tvalid,
    output logic              s1_tready,

    input  logic              send_fifo_almost_full,

    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,

    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic              overlong
);

    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    // State encoding doubles as the one-hot grant vector {s1,s0}.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t              state;
    logic                favour_s1;
    logic [BEAT_W-1:0]   beat_cnt;

    logic                slice_ready;
    logic                accept;
    logic                at_limit;
    logic                pkt_end;
    logic [DATA_W-1:0]   sel_data;
    logic [KEEP_W-1:0]   sel_keep;
    logic                sel_last;

    assign grant = state;

    // The slice can take a new beat when empty or when its beat drains now.
    assign slice_ready = !m_tvalid || m_tready;
    assign s0_tready   = (state == GNT0) && slice_ready;
    assign s1_tready   = (state == GNT1) && slice_ready;

    assign accept   = (s0_tvalid && s0_tready) || (s1_tvalid && s1_tready);
    assign at_limit = (beat_cnt == LAST_BEAT);
    assign pkt_end  = accept && (sel_last || at_limit);

    // Route the granted source towards the output slice.
    always_comb begin
        sel_data = s0_tdata;
        sel_keep = s0_tkeep;
        sel_last = s0_tlast;
        if (state == GNT1) begin
            sel_data = s1_tdata;
            sel_keep = s1_tkeep;
            sel_last = s1_tlast;
        end
    end

    // Arbitration FSM with packet accounting. Leaving a grant always passes
    // through IDLE, which gives the one-cycle gap between packets.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            favour_s1 <= 1'b0;
            beat_cnt  <= '0;
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
            overlong  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!send_fifo_almost_full) begin
                        if (s0_tvalid && s1_tvalid) begin
                            state <= favour_s1 ? GNT1 : GNT0;
                        end else if (s0_tvalid) begin
                            state <= GNT0;
                        end else if (s1_tvalid) begin
                            state <= GNT1;
                        end
                    end
                end
                GNT0, GNT1: begin
                    if (accept) begin
                        if (pkt_end) begin
                            state     <= IDLE;
                            favour_s1 <= (state == GNT0);
                            beat_cnt  <= '0;
                            if (state == GNT0) begin
                                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
                            end else begin
                                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
                            end
                            if (at_limit && !sel_last) begin
                                overlong <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered output slice: holds its beat while stalled, reloads on the
    // same edge the previous beat drains. A forced end marks the beat as last.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
        end else if (slice_ready) begin
            m_tvalid <= accept;
            if (accept) begin
                m_tdata <= sel_data;
                m_tkeep <= sel_keep;
                m_tlast <= sel_last || at_limit;
            end
        end
    end

endmodule

// File: tb/tb_axis_send_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_send_arbiter
//
// Directed bench for axis_send_arbiter. Two instances share the stimulus:
// dut_a with the default MAX_BEATS and dut_b with MAX_BEATS=4 for the
// forced-end scenario; use4 selects which instance the source model and the
// checks follow. Sources present their beats from queues and advance only on
// a handshake; every beat taken by the sink is recorded in order.
// ---------------------------------------------------------------------------
module tb_axis_send_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] s0_tdata, s1_tdata;
    logic [3:0]  s0_tkeep, s1_tkeep;
    logic        s0_tlast, s1_tlast, s0_tvalid, s1_tvalid;
    logic        send_fifo_almost_full;
    logic        m_tready;

    logic        s0_tready_a, s1_tready_a, s0_tready_b, s1_tready_b;
    logic [31:0] m_tdata_a, m_tdata_b;
    logic [3:0]  m_tkeep_a, m_tkeep_b;
    logic        m_tlast_a, m_tlast_b, m_tvalid_a, m_tvalid_b;
    logic [1:0]  grant_a, grant_b;
    logic [15:0] pkt_cnt0_a, pkt_cnt1_a, pkt_cnt0_b, pkt_cnt1_b;
    logic        overlong_a, overlong_b;

    bit          use4 = 1'b0;

    logic        cur_s0_tready, cur_s1_tready, cur_m_tvalid, cur_m_tlast, cur_overlong;
    logic [31:0] cur_m_tdata;
    logic [3:0]  cur_m_tkeep;
    logic [1:0]  cur_grant;
    logic [15:0] cur_pkt_cnt0, cur_pkt_cnt1;

    assign cur_s0_tready = use4 ? s0_tready_b : s0_tready_a;
    assign cur_s1_tready = use4 ? s1_tready_b : s1_tready_a;
    assign cur_m_tvalid  = use4 ? m_tvalid_b  : m_tvalid_a;
    assign cur_m_tlast   = use4 ? m_tlast_b   : m_tlast_a;
    assign cur_m_tdata   = use4 ? m_tdata_b   : m_tdata_a;
    assign cur_m_tkeep   = use4 ? m_tkeep_b   : m_tkeep_a;
    assign cur_grant     = use4 ? grant_b     : grant_a;
    assign cur_pkt_cnt0  = use4 ? pkt_cnt0_b  : pkt_cnt0_a;
    assign cur_pkt_cnt1  = use4 ? pkt_cnt1_b  : pkt_cnt1_a;
    assign cur_overlong  = use4 ? overlong_b  : overlong_a;

    axis_send_arbiter dut_a (
        .clock(clock), .reset(reset),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready_a),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready_a),
        .send_fifo_almost_full(send_fifo_almost_full),
        .m_tdata(m_tdata_a), .m_tkeep(m_tkeep_a), .m_tlast(m_tlast_a),
        .m_tvalid(m_tvalid_a), .m_tready(m_tready),
        .grant(grant_a), .pkt_cnt0(pkt_cnt0_a), .pkt_cnt1(pkt_cnt1_a),
        .overlong(overlong_a)
    );

    axis_send_arbiter #(.MAX_BEATS(4)) dut_b (
        .clock(clock), .reset(reset),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready_b),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready_b),
        .send_fifo_almost_full(send_fifo_almost_full),
        .m_tdata(m_tdata_b), .m_tkeep(m_tkeep_b), .m_tlast(m_tlast_b),
        .m_tvalid(m_tvalid_b), .m_tready(m_tready),
        .grant(grant_b), .pkt_cnt0(pkt_cnt0_b), .pkt_cnt1(pkt_cnt1_b),
        .overlong(overlong_b)
    );

    always #5 clock = ~clock;

    int          compared = 0;
    int          mismatched = 0;

    logic [31:0] q0d[$], q1d[$], rxd[$], expD[$];
    bit          q0l[$], q1l[$], rxl[$], expL[$];
    logic [1:0]  grantLog[$];
    int          idx0, idx1;
    bit          toggleReady, checkStable, prevStall;
    logic [31:0] prevData;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present each source's current queued beat, or idle when exhausted.
    task automatic driveSources();
        s0_tvalid = (idx0 < q0d.size());
        s0_tdata  = s0_tvalid ? q0d[idx0] : 32'h0;
        s0_tlast  = s0_tvalid ? q0l[idx0] : 1'b0;
        s0_tkeep  = s0_tvalid ? 4'hF : 4'h0;
        s1_tvalid = (idx1 < q1d.size());
        s1_tdata  = s1_tvalid ? q1d[idx1] : 32'h0;
        s1_tlast  = s1_tvalid ? q1l[idx1] : 1'b0;
        s1_tkeep  = s1_tvalid ? 4'hF : 4'h0;
    endtask

    // One clock cycle: sample handshakes mid-cycle, then advance the model
    // and drive new inputs just after the rising edge.
    task automatic applyStimulus();
        bit acc0, acc1;
        @(negedge clock);
        acc0 = s0_tvalid && cur_s0_tready;
        acc1 = s1_tvalid && cur_s1_tready;
        if (checkStable && prevStall) begin
            checkOutput("stall_hold_valid", {31'b0, cur_m_tvalid}, 32'd1);
            checkOutput("stall_hold_data", cur_m_tdata, prevData);
        end
        prevStall = cur_m_tvalid && !m_tready;
        prevData  = cur_m_tdata;
        if (cur_m_tvalid && m_tready) begin
            rxd.push_back(cur_m_tdata);
            rxl.push_back(cur_m_tlast);
        end
        @(posedge clock);
        #1;
        if (acc0) idx0++;
        if (acc1) idx1++;
        if (toggleReady) m_tready = !m_tready;
        grantLog.push_back(cur_grant);
        driveSources();
    endtask

    task automatic runUntilDone(input int maxCycles, input string tag);
        int n = 0;
        bit pending;
        pending = (idx0 < q0d.size()) || (idx1 < q1d.size()) || cur_m_tvalid;
        while (pending && n < maxCycles) begin
            applyStimulus();
            n++;
            pending = (idx0 < q0d.size()) || (idx1 < q1d.size()) || cur_m_tvalid;
        end
        checkOutput(tag, {31'b0, !pending}, 32'd1);
    endtask

    task automatic checkRx(input string tag);
        checkOutput($sformatf("%s_len", tag), rxd.size(), expD.size());
        for (int i = 0; i < expD.size(); i++) begin
            if (i < rxd.size()) begin
                checkOutput($sformatf("%s_data%0d", tag, i), rxd[i], expD[i]);
                checkOutput($sformatf("%s_last%0d", tag, i), {31'b0, rxl[i]}, {31'b0, expL[i]});
            end
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        q0d.delete(); q0l.delete(); q1d.delete(); q1l.delete();
        rxd.delete(); rxl.delete(); expD.delete(); expL.delete();
        grantLog.delete();
        idx0 = 0; idx1 = 0;
        toggleReady = 0; checkStable = 0; prevStall = 0;
        m_tready = 1'b1;
        send_fifo_almost_full = 1'b0;
        driveSources();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int zeros;
        bit seen0;
        int guard;

        // Reset state, with s0 asserting valid during reset.
        idx0 = 0; idx1 = 0;
        m_tready = 1'b1;
        send_fifo_almost_full = 1'b0;
        q0d.push_back(32'hAA); q0l.push_back(1'b1);
        driveSources();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_grant", {30'b0, cur_grant}, 32'd0);
        checkOutput("rst_m_tvalid", {31'b0, cur_m_tvalid}, 32'd0);
        checkOutput("rst_m_tdata", cur_m_tdata, 32'd0);
        checkOutput("rst_s0_tready", {31'b0, cur_s0_tready}, 32'd0);
        checkOutput("rst_pkt_cnt0", {16'b0, cur_pkt_cnt0}, 32'd0);
        checkOutput("rst_overlong", {31'b0, cur_overlong}, 32'd0);

        // Test 1: single 4-beat packet from s0.
        $display("[TB] test 1: single s0 packet");
        resetDut();
        for (int i = 1; i <= 4; i++) begin
            q0d.push_back(32'(i)); q0l.push_back(i == 4);
        end
        driveSources();
        checkOutput("t1_grant_idle", {30'b0, cur_grant}, 32'd0);
        applyStimulus();
        checkOutput("t1_grant", {30'b0, cur_grant}, 32'd1);
        checkOutput("t1_m_tvalid_pre", {31'b0, cur_m_tvalid}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("t1_valid%0d", i), {31'b0, cur_m_tvalid}, 32'd1);
            checkOutput($sformatf("t1_data%0d", i), cur_m_tdata, 32'(i));
            checkOutput($sformatf("t1_last%0d", i), {31'b0, cur_m_tlast}, {31'b0, (i == 4)});
        end
        checkOutput("t1_keep", {28'b0, cur_m_tkeep}, 32'hF);
        checkOutput("t1_pkt_cnt0", {16'b0, cur_pkt_cnt0}, 32'd1);
        checkOutput("t1_grant_end", {30'b0, cur_grant}, 32'd0);
        applyStimulus();
        checkOutput("t1_drained", {31'b0, cur_m_tvalid}, 32'd0);

        // Test 2: both sources valid, s0 favoured out of reset.
        $display("[TB] test 2: contention");
        resetDut();
        for (int i = 1; i <= 3; i++) begin
            q0d.push_back(32'h10 + 32'(i)); q0l.push_back(i == 3);
            q1d.push_back(32'h20 + 32'(i)); q1l.push_back(i == 3);
        end
        driveSources();
        runUntilDone(60, "t2_done");
        expD = '{32'h11, 32'h12, 32'h13, 32'h21, 32'h22, 32'h23};
        expL = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        checkRx("t2");
        zeros = 0; seen0 = 0;
        foreach (grantLog[i]) begin
            if (grantLog[i] == 2'b01) seen0 = 1;
            else if (grantLog[i] == 2'b10) break;
            else if (seen0) zeros++;
        end
        checkOutput("t2_gap", zeros, 32'd1);
        checkOutput("t2_pkt_cnt0", {16'b0, cur_pkt_cnt0}, 32'd1);
        checkOutput("t2_pkt_cnt1", {16'b0, cur_pkt_cnt1}, 32'd1);

        // Test 3: almost_full blocks a new packet.
        $display("[TB] test 3: almost_full at packet start");
        resetDut();
        send_fifo_almost_full = 1'b1;
        q1d.push_back(32'h31); q1l.push_back(1'b0);
        q1d.push_back(32'h32); q1l.push_back(1'b1);
        driveSources();
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput($sformatf("t3_grant_blk%0d", i), {30'b0, cur_grant}, 32'd0);
            checkOutput($sformatf("t3_tready_blk%0d", i), {31'b0, cur_s1_tready}, 32'd0);
        end
        send_fifo_almost_full = 1'b0;
        applyStimulus();
        checkOutput("t3_grant", {30'b0, cur_grant}, 32'd2);
        runUntilDone(40, "t3_done");
        expD = '{32'h31, 32'h32};
        expL = '{1'b0, 1'b1};
        checkRx("t3");
        checkOutput("t3_pkt_cnt1", {16'b0, cur_pkt_cnt1}, 32'd1);

        // Test 4: almost_full rising mid-packet does not stall the packet.
        $display("[TB] test 4: almost_full mid-packet");
        resetDut();
        for (int i = 1; i <= 5; i++) begin
            q0d.push_back(32'h40 + 32'(i)); q0l.push_back(i == 5);
        end
        driveSources();
        guard = 0;
        while (idx0 < 2 && guard < 20) begin
            applyStimulus();
            guard++;
        end
        send_fifo_almost_full = 1'b1;
        runUntilDone(40, "t4_done");
        expD = '{32'h41, 32'h42, 32'h43, 32'h44, 32'h45};
        expL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checkRx("t4");
        checkOutput("t4_pkt_cnt0", {16'b0, cur_pkt_cnt0}, 32'd1);

        // Test 5: sink backpressure alternating each cycle.
        $display("[TB] test 5: m_tready toggling");
        resetDut();
        for (int i = 1; i <= 8; i++) begin
            q0d.push_back(32'h50 + 32'(i)); q0l.push_back(i == 8);
        end
        driveSources();
        toggleReady = 1;
        checkStable = 1;
        runUntilDone(100, "t5_done");
        toggleReady = 0;
        checkStable = 0;
        m_tready = 1'b1;
        expD = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 32'h56, 32'h57, 32'h58};
        expL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checkRx("t5");
        checkOutput("t5_pkt_cnt0", {16'b0, cur_pkt_cnt0}, 32'd1);

        // Test 6: MAX_BEATS=4 instance, 6-beat packet splits into 4 + 2.
        $display("[TB] test 6: forced end and mid-packet reset");
        use4 = 1'b1;
        resetDut();
        for (int i = 1; i <= 6; i++) begin
            q1d.push_back(32'h60 + 32'(i)); q1l.push_back(i == 6);
        end
        driveSources();
        runUntilDone(60, "t6_done");
        expD = '{32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 32'h66};
        expL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        checkRx("t6");
        checkOutput("t6_overlong", {31'b0, cur_overlong}, 32'd1);
        checkOutput("t6_pkt_cnt1", {16'b0, cur_pkt_cnt1}, 32'd2);

        // Start another packet, then assert reset between clock edges.
        q1d.push_back(32'h71); q1l.push_back(1'b0);
        q1d.push_back(32'h72); q1l.push_back(1'b0);
        q1d.push_back(32'h73); q1l.push_back(1'b1);
        driveSources();
        repeat (3) applyStimulus();
        checkOutput("t6_pre_rst_valid", {31'b0, cur_m_tvalid}, 32'd1);
        checkOutput("t6_pre_rst_data", cur_m_tdata, 32'h72);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_m_tvalid", {31'b0, cur_m_tvalid}, 32'd0);
        checkOutput("t6_rst_m_tdata", cur_m_tdata, 32'd0);
        checkOutput("t6_rst_m_tlast", {31'b0, cur_m_tlast}, 32'd0);
        checkOutput("t6_rst_grant", {30'b0, cur_grant}, 32'd0);
        checkOutput("t6_rst_s1_tready", {31'b0, cur_s1_tready}, 32'd0);
        checkOutput("t6_rst_overlong", {31'b0, cur_overlong}, 32'd0);
        checkOutput("t6_rst_pkt_cnt1", {16'b0, cur_pkt_cnt1}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
